serdes_link_watchdog: RTL

//  Per-lane SerDes link supervisor for multi-lane boards. Replaces the single-lane fixed 2 s poll.

---
 rtl/serdes_link_watchdog_if.sv | 30 +++
 rtl/serdes_link_watchdog.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/serdes_link_watchdog_if.sv
`default_nettype none
// ============================================================================
// Module      : serdes_link_watchdog_if
// Description : Lane status and GTP reset bundle for the link watchdog.
// Revision    : 1.0
// ============================================================================
interface serdes_link_watchdog_if #(
  parameter int LANES = 4
);
  logic [LANES-1:0]    lane_up;
  logic [LANES-1:0]    channel_up;
  logic [LANES-1:0]    force_rst;
  logic [LANES-1:0]    clear_fail;
  logic [LANES-1:0]    gtp_rst;
  logic [LANES-1:0]    link_ok;
  logic [LANES-1:0]    fail;
  logic [8*LANES-1:0]  retry_cnt;
  logic [16*LANES-1:0] relink_cnt;

  modport master (
    output lane_up, channel_up, force_rst, clear_fail,
    input  gtp_rst, link_ok, fail, retry_cnt, relink_cnt
  );

  modport slave (
    input  lane_up, channel_up, force_rst, clear_fail,
    output gtp_rst, link_ok, fail, retry_cnt, relink_cnt
  );
endinterface
`default_nettype wire

// File: rtl/serdes_link_watchdog.sv
`default_nettype none
// ============================================================================
// Module      : serdes_link_watchdog
// Description : Per-lane SerDes supervisor: reset pulse, lock wait with
//               timeout and bounded retry, glitch-filtered UP, sticky FAIL.
//               Define LINK_WDG_STATS_EN to build the relink counters.
// Revision    : 1.0
// ============================================================================
module serdes_link_watchdog #(
  parameter int LANES         = 4,
  parameter int CNT_W         = 28,
  parameter int RST_PULSE     = 16384,
  parameter int LOCK_TIMEOUT  = 67108864,
  parameter int STABLE_CYCLES = 1024,
  parameter int DROP_FILTER   = 16,
  parameter int MAX_RETRY     = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  serdes_link_watchdog_if.slave bus
);

  typedef enum logic [1:0] {
    ST_RST  = 2'd0,
    ST_WAIT = 2'd1,
    ST_UP   = 2'd2,
    ST_FAIL = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] C_RST_LAST  = CNT_W'(RST_PULSE - 1);
  localparam logic [CNT_W-1:0] C_LOCK_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] C_STABLE    = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] C_DROP      = CNT_W'(DROP_FILTER);
  localparam logic [7:0]       C_MAX_RETRY = 8'(MAX_RETRY);

  logic [LANES-1:0] lane_s1_q, lane_s2_q, chan_s1_q, chan_s2_q;
  logic [LANES-1:0] up_s;

  // Each status input gets its own two-flop synchroniser before the AND.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_s1_q <= '0;
      lane_s2_q <= '0;
      chan_s1_q <= '0;
      chan_s2_q <= '0;
    end else begin
      lane_s1_q <= bus.lane_up;
      lane_s2_q <= lane_s1_q;
      chan_s1_q <= bus.channel_up;
      chan_s2_q <= chan_s1_q;
    end
  end

  assign up_s = lane_s2_q & chan_s2_q;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    state_e           state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic [CNT_W-1:0] run_q, run_d;
    logic [7:0]       retry_q, retry_d;
    logic             gtp_rst_q, gtp_rst_d;
    logic             link_ok_q, link_ok_d;
    logic             fail_q, fail_d;

    // run_q is the stable-up count in WAIT and the consecutive-down count in UP.
    always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      run_d   = '0;
      retry_d = retry_q;
      case (state_q)
        ST_RST: begin
          timer_d = timer_q + 1'b1;
          if (timer_q == C_RST_LAST) state_d = ST_WAIT;
        end
        ST_WAIT: begin
          timer_d = timer_q + 1'b1;
          run_d   = up_s[i] ? run_q + 1'b1 : '0;
          if (run_d == C_STABLE) begin
            state_d = ST_UP;
            retry_d = 8'd0;
          end else if (timer_q == C_LOCK_LAST) begin
            retry_d = retry_q + 8'd1;
            state_d = (retry_d == C_MAX_RETRY) ? ST_FAIL : ST_RST;
          end
        end
        ST_UP: begin
          run_d = up_s[i] ? '0 : run_q + 1'b1;
          if (run_d == C_DROP) state_d = ST_RST;
        end
        ST_FAIL: begin
          if (bus.clear_fail[i]) begin
            state_d = ST_RST;
            retry_d = 8'd0;
          end
        end
        default: state_d = ST_RST;
      endcase
      if (bus.force_rst[i]) begin
        state_d = ST_RST;
        retry_d = 8'd0;
      end
      if ((state_d != state_q) || bus.force_rst[i]) begin
        timer_d = '0;
        run_d   = '0;
      end
      gtp_rst_d = (state_d == ST_RST) || (state_d == ST_FAIL);
      link_ok_d = (state_d == ST_UP);
      fail_d    = (state_d == ST_FAIL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q   <= ST_RST;
        timer_q   <= '0;
        run_q     <= '0;
        retry_q   <= 8'd0;
        gtp_rst_q <= 1'b1;
        link_ok_q <= 1'b0;
        fail_q    <= 1'b0;
      end else begin
        state_q   <= state_d;
        timer_q   <= timer_d;
        run_q     <= run_d;
        retry_q   <= retry_d;
        gtp_rst_q <= gtp_rst_d;
        link_ok_q <= link_ok_d;
        fail_q    <= fail_d;
      end
    end

    assign bus.gtp_rst[i]           = gtp_rst_q;
    assign bus.link_ok[i]           = link_ok_q;
    assign bus.fail[i]              = fail_q;
    assign bus.retry_cnt[8*i +: 8]  = retry_q;

`ifdef LINK_WDG_STATS_EN
    logic        relink_inc;
    logic [15:0] relink_q, relink_d;

    // Only a filtered drop counts; a forced restart out of UP does not.
    assign relink_inc = (state_q == ST_UP) && (state_d == ST_RST) && !bus.force_rst[i];

    always_comb begin
      relink_d = relink_q;
      if (relink_inc && (relink_q != 16'hFFFF)) relink_d = relink_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) relink_q <= 16'd0;
      else        relink_q <= relink_d;
    end

    assign bus.relink_cnt[16*i +: 16] = relink_q;
`else
    assign bus.relink_cnt[16*i +: 16] = 16'd0;
`endif
  end

endmodule
`default_nettype wire
